dbg_guv_cmd_assembler: RTL and testbench

- Upstream stage of the debug governor's command FSM.
- Takes a byte-wide AXI-Stream command channel from the host or debug link and packs each 4-byte frame into one 29-bit command word.
- Frames whose address does not match this governor are discarded, and malformed frames are rejected.
- Accepted words are held in a one-entry output register and driven on the cmd_out AXI-Stream, which connects straight to the FSM's cmd_in port.

---
 rtl/dbg_guv_cmd_assembler.sv | 140 ++++++++++++++
 tb/tb_dbg_guv_cmd_assembler.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_guv_cmd_assembler.sv
// Debug governor command assembler.
// Packs little-endian 4-byte frames from a byte-wide AXI-Stream into 29-bit
// command words. Frames addressed to another governor are dropped with an
// err_addr pulse, and short or long frames are dropped with an err_frame pulse.
// Accepted words are held in a one-entry output register.
// Optional feature macro: DBG_GUV_CMD_ERR_CNT_EN adds a saturating error
// counter on port err_cnt.
module dbg_guv_cmd_assembler #(
    parameter logic [2:0] GUV_ADDR  = 3'd0,
    parameter bit         DROP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  cmd_byte_TDATA,
    input  logic        cmd_byte_TVALID,
    output logic        cmd_byte_TREADY,
    input  logic        cmd_byte_TLAST,
    output logic [28:0] cmd_out_TDATA,
    output logic        cmd_out_TVALID,
    input  logic        cmd_out_TREADY,
    output logic        err_frame,
    output logic        err_addr
`ifdef DBG_GUV_CMD_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam logic [0:0] ST_RX    = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]  state;
    logic [1:0]  byte_cnt;
    logic [23:0] acc;
    logic        rdy_en;

    logic        byte_acc;
    logic        in_rx;
    logic        at_b3;
    logic        ev_short;
    logic        ev_long;
    logic        ev_addr;
    logic        ev_good;
    logic        load;
    logic [28:0] word;

    // Byte 3 is held off only while a word is pending and not being consumed
    assign cmd_byte_TREADY = rdy_en &&
                             ((state == ST_FLUSH) || (byte_cnt != 2'd3) ||
                              !cmd_out_TVALID || cmd_out_TREADY);

    // Decode the outcome of the byte being accepted this cycle
    always_comb begin
        byte_acc = cmd_byte_TVALID && cmd_byte_TREADY;
        in_rx    = (state == ST_RX);
        at_b3    = (byte_cnt == 2'd3);
        word     = {cmd_byte_TDATA[4:0], acc};
        ev_short = byte_acc && in_rx && !at_b3 && cmd_byte_TLAST;
        ev_long  = byte_acc && in_rx && at_b3 && !cmd_byte_TLAST;
        ev_addr  = byte_acc && in_rx && at_b3 && cmd_byte_TLAST &&
                   (cmd_byte_TDATA[7:5] != GUV_ADDR);
        ev_good  = byte_acc && in_rx && at_b3 && cmd_byte_TLAST &&
                   (cmd_byte_TDATA[7:5] == GUV_ADDR);
        load     = ev_good && !(DROP_ZERO && (word == '0));
    end

    // Frame state, byte lane counter and accumulator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RX;
            byte_cnt <= '0;
            acc      <= '0;
            rdy_en   <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (byte_acc) begin
                if (state == ST_FLUSH) begin
                    if (cmd_byte_TLAST) begin
                        state    <= ST_RX;
                        byte_cnt <= '0;
                    end
                end else if (!at_b3) begin
                    if (cmd_byte_TLAST) begin
                        byte_cnt <= '0;
                        acc      <= '0;
                    end else begin
                        case (byte_cnt)
                            2'd0:    acc[7:0]   <= cmd_byte_TDATA;
                            2'd1:    acc[15:8]  <= cmd_byte_TDATA;
                            default: acc[23:16] <= cmd_byte_TDATA;
                        endcase
                        byte_cnt <= byte_cnt + 2'd1;
                    end
                end else begin
                    byte_cnt <= '0;
                    acc      <= '0;
                    if (!cmd_byte_TLAST) begin
                        state <= ST_FLUSH;
                    end
                end
            end
        end
    end

    // One-entry output register; a new load wins over a same-cycle handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_out_TDATA  <= '0;
            cmd_out_TVALID <= 1'b0;
        end else if (load) begin
            cmd_out_TDATA  <= word;
            cmd_out_TVALID <= 1'b1;
        end else if (cmd_out_TVALID && cmd_out_TREADY) begin
            cmd_out_TVALID <= 1'b0;
        end
    end

    // Single-cycle error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_frame <= 1'b0;
            err_addr  <= 1'b0;
        end else begin
            err_frame <= ev_short || ev_long;
            err_addr  <= ev_addr;
        end
    end

`ifdef DBG_GUV_CMD_ERR_CNT_EN
    // Saturating count of framing and address errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= '0;
        end else if ((ev_short || ev_long || ev_addr) && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dbg_guv_cmd_assembler.sv
// Testbench for dbg_guv_cmd_assembler: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_dbg_guv_cmd_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  cmd_byte_TDATA;
    logic        cmd_byte_TVALID;
    logic        cmd_byte_TREADY;
    logic        cmd_byte_TLAST;
    logic [28:0] cmd_out_TDATA;
    logic        cmd_out_TVALID;
    logic        cmd_out_TREADY;
    logic        err_frame;
    logic        err_addr;
`ifdef DBG_GUV_CMD_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int asserts  = 0;
    int failures = 0;

    // Reference model state
    logic [28:0] exp_q[$];
    logic [28:0] got_q[$];
    int          exp_frame_errs = 0;
    int          exp_addr_errs  = 0;
    logic [7:0]  fb[0:7];

    // Monitor observations
    int          mon_frame = 0;
    int          mon_addr  = 0;
    int          stab_viol = 0;
    int          both_viol = 0;
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [28:0] prev_d = '0;

    int          tr_mode = 0;  // 0: ready, 1: random, 2: stalled

    dbg_guv_cmd_assembler #(
        .GUV_ADDR (3'd0),
        .DROP_ZERO(1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_byte_TDATA (cmd_byte_TDATA),
        .cmd_byte_TVALID(cmd_byte_TVALID),
        .cmd_byte_TREADY(cmd_byte_TREADY),
        .cmd_byte_TLAST (cmd_byte_TLAST),
        .cmd_out_TDATA  (cmd_out_TDATA),
        .cmd_out_TVALID (cmd_out_TVALID),
        .cmd_out_TREADY (cmd_out_TREADY),
        .err_frame      (err_frame),
        .err_addr       (err_addr)
`ifdef DBG_GUV_CMD_ERR_CNT_EN
        ,
        .err_cnt        (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Downstream ready pattern
    always @(posedge clk) begin
        #1;
        case (tr_mode)
            0:       cmd_out_TREADY = 1'b1;
            2:       cmd_out_TREADY = 1'b0;
            default: cmd_out_TREADY = ($urandom_range(0, 1) == 1);
        endcase
    end

    // Record output handshakes, error pulses and stability violations
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r &&
                (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== prev_d))
                stab_viol++;
            if (cmd_out_TVALID === 1'b1 && cmd_out_TREADY === 1'b1)
                got_q.push_back(cmd_out_TDATA);
            if (err_frame === 1'b1) mon_frame++;
            if (err_addr === 1'b1) mon_addr++;
            if (err_frame === 1'b1 && err_addr === 1'b1) both_viol++;
            prev_v = cmd_out_TVALID;
            prev_r = cmd_out_TREADY;
            prev_d = cmd_out_TDATA;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1);
    end

    // Frame-level model: a frame is good only if it is exactly 4 bytes long
    task automatic model_frame(input int n);
        logic [28:0] w;
        if (n != 4) begin
            exp_frame_errs++;
        end else if (fb[3][7:5] != 3'd0) begin
            exp_addr_errs++;
        end else begin
            w = {fb[3][4:0], fb[2], fb[1], fb[0]};
            if (w != 29'd0) exp_q.push_back(w);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        n = 0;
        cmd_byte_TDATA  = d;
        cmd_byte_TLAST  = l;
        cmd_byte_TVALID = 1'b1;
        @(negedge clk);
        while (cmd_byte_TREADY !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (cmd_byte_TREADY !== 1'b1) begin
            asserts++;
            failures++;
            $display("FAIL byte_accept_timeout: TREADY=%b required 1", cmd_byte_TREADY);
        end
        @(posedge clk);
        #1;
        cmd_byte_TVALID = 1'b0;
        cmd_byte_TLAST  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int gap_max);
        model_frame(n);
        for (int i = 0; i < n; i++) begin
            send_byte(fb[i], i == n - 1);
            if (gap_max > 0) begin
                repeat ($urandom_range(0, gap_max)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic set_fb4(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        fb[0] = b0; fb[1] = b1; fb[2] = b2; fb[3] = b3;
    endtask

    task automatic check_sb(input string name);
        int t;
        logic [28:0] e;
        logic [28:0] g;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 400) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        asserts++;
        if (got_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s word_count: got %0d required %0d", name, got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            asserts++;
            if (g !== e) begin
                failures++;
                $display("FAIL %s word: got %h required %h", name, g, e);
            end
        end
        got_q.delete();
        exp_q.delete();
        asserts++;
        if (mon_frame != exp_frame_errs) begin
            failures++;
            $display("FAIL %s err_frame_pulses: got %0d required %0d", name, mon_frame, exp_frame_errs);
        end
        asserts++;
        if (mon_addr != exp_addr_errs) begin
            failures++;
            $display("FAIL %s err_addr_pulses: got %0d required %0d", name, mon_addr, exp_addr_errs);
        end
        asserts++;
        if (stab_viol != 0) begin
            failures++;
            $display("FAIL %s output_stability: got %0d violations required 0", name, stab_viol);
        end
        asserts++;
        if (both_viol != 0) begin
            failures++;
            $display("FAIL %s dual_error: got %0d required 0", name, both_viol);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        asserts++;
        if (cmd_byte_TREADY !== 1'b0 || cmd_out_TVALID !== 1'b0 || cmd_out_TDATA !== 29'd0 ||
            err_frame !== 1'b0 || err_addr !== 1'b0) begin
            failures++;
            $display("FAIL %s: tready=%b tvalid=%b tdata=%h errf=%b erra=%b required 0 0 0 0 0",
                     name, cmd_byte_TREADY, cmd_out_TVALID, cmd_out_TDATA, err_frame, err_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_values");
        rst = 1'b0;
        #1;
        asserts++;
        if (cmd_byte_TREADY !== 1'b0) begin
            failures++;
            $display("FAIL reset_tready_before_clock: got %b required 0", cmd_byte_TREADY);
        end
        @(negedge clk);
        asserts++;
        if (cmd_byte_TREADY !== 1'b1) begin
            failures++;
            $display("FAIL reset_tready_after_clock: got %b required 1", cmd_byte_TREADY);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        set_fb4(8'h0D, 8'h00, 8'h00, 8'h00);
        send_frame(4, 0);
        asserts++;
        if (cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 29'h000000D) begin
            failures++;
            $display("FAIL basic_latency: tvalid=%b tdata=%h required 1 000000d", cmd_out_TVALID, cmd_out_TDATA);
        end
        check_sb("basic");
    endtask

    task automatic test_addr();
        set_fb4(8'h00, 8'h00, 8'h00, 8'h20);
        send_frame(4, 0);
        set_fb4(8'h44, 8'h33, 8'h22, 8'h01);
        send_frame(4, 0);
        check_sb("addr_mismatch");
    endtask

    task automatic test_short();
        fb[0] = 8'hAA;
        fb[1] = 8'hBB;
        send_frame(2, 0);
        set_fb4(8'h11, 8'h22, 8'h33, 8'h04);
        send_frame(4, 0);
        check_sb("short_frame");
    endtask

    task automatic test_long();
        for (int i = 0; i < 6; i++) fb[i] = 8'(i + 1);
        send_frame(6, 0);
        set_fb4(8'h78, 8'h56, 8'h34, 8'h12);
        send_frame(4, 0);
        check_sb("long_frame");
    endtask

    task automatic test_back_to_back();
        tr_mode = 2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        set_fb4(8'h01, 8'h02, 8'h03, 8'h04);
        send_frame(4, 0);
        set_fb4(8'h05, 8'h06, 8'h07, 8'h08);
        model_frame(4);
        for (int i = 0; i < 3; i++) send_byte(fb[i], 1'b0);
        cmd_byte_TDATA  = fb[3];
        cmd_byte_TLAST  = 1'b1;
        cmd_byte_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            asserts++;
            if (cmd_byte_TREADY !== 1'b0 || cmd_out_TVALID !== 1'b1 || cmd_out_TDATA !== 29'h04030201) begin
                failures++;
                $display("FAIL backpressure_hold: tready=%b tvalid=%b tdata=%h required 0 1 04030201",
                         cmd_byte_TREADY, cmd_out_TVALID, cmd_out_TDATA);
            end
        end
        tr_mode = 0;
        send_byte(fb[3], 1'b1);
        check_sb("back_to_back");
    endtask

    task automatic test_drop_zero();
        set_fb4(8'h00, 8'h00, 8'h00, 8'h00);
        send_frame(4, 0);
        check_sb("drop_zero");
    endtask

    task automatic test_reset_mid();
        tr_mode = 2;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        send_byte(8'h21, 1'b0);
        send_byte(8'h43, 1'b0);
        send_byte(8'h65, 1'b0);
        send_byte(8'h07, 1'b1);
        send_byte(8'h99, 1'b0);
        send_byte(8'h88, 1'b0);
        rst = 1'b1;
        #2;
        check_reset_outputs("reset_mid_frame");
        tr_mode = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        set_fb4(8'hEF, 8'hBE, 8'hAD, 8'h1E);
        send_frame(4, 0);
        check_sb("reset_mid_frame");
    endtask

    task automatic test_random();
        int r;
        int n;
        tr_mode = 1;
        for (int f = 0; f < 80; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 6) n = 4;
            else if (r < 8) n = int'($urandom_range(1, 3));
            else n = int'($urandom_range(5, 8));
            for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
            if ($urandom_range(0, 3) != 0) fb[3][7:5] = 3'd0;
            if ($urandom_range(0, 15) == 0) set_fb4(8'h00, 8'h00, 8'h00, 8'h00);
            send_frame(n, 2);
        end
        tr_mode = 0;
        check_sb("random");
    endtask

`ifdef DBG_GUV_CMD_ERR_CNT_EN
    task automatic test_err_cnt();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        asserts++;
        if (err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL err_cnt_reset: got %0d required 0", err_cnt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            fb[0] = 8'($urandom);
            send_frame(1, 0);
        end
        check_sb("err_cnt_10");
        asserts++;
        if (err_cnt !== 8'd10) begin
            failures++;
            $display("FAIL err_cnt_10: got %0d required 10", err_cnt);
        end
        for (int i = 0; i < 290; i++) begin
            fb[0] = 8'($urandom);
            send_frame(1, 0);
        end
        check_sb("err_cnt_300");
        asserts++;
        if (err_cnt !== 8'd255) begin
            failures++;
            $display("FAIL err_cnt_saturate: got %0d required 255", err_cnt);
        end
    endtask
`endif

    initial begin
        rst             = 1'b1;
        cmd_byte_TDATA  = '0;
        cmd_byte_TVALID = 1'b0;
        cmd_byte_TLAST  = 1'b0;
        cmd_out_TREADY  = 1'b1;
        test_reset();
        test_basic();
        test_addr();
        test_short();
        test_long();
        test_back_to_back();
        test_drop_zero();
        test_reset_mid();
        test_random();
`ifdef DBG_GUV_CMD_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule
